// File: rtl/montgomery_to_form_bs.sv
// -----------------------------------------------------------------------------
// montgomery_to_form_bs
//
// Bit-serial conversion of an integer x into Montgomery form
//    xm = x * 2^k mod m,  with k = modulus bit length (R = 2^k).
// The block sits directly upstream of the bit-serial Montgomery reduction
// stage: result_o / valid_o feed that stage's x_i / start_i, and m_i / m_bl_i
// are shared with it. Only shift, compare and subtract are used.
//
// Operation:
//   REDUCE : DATA_W cycles, MSB first, r = 2r + x[bit], conditional -m
//            -> leaves r = x mod m
//   SCALE  : k cycles, r = 2r, conditional -m
//            -> leaves r = x * 2^k mod m
//   DONE   : one cycle, valid_o pulses, result_o already holds r
//
// Handshake: start_i is sampled only in IDLE. Requests arriving while busy_o
// is high or in DONE are dropped, not queued. valid_o is a single-cycle
// pulse coinciding with the first cycle in which result_o shows the new
// value; result_o then holds until the next accepted start.
//
// Optional build macro MONT_FAST_REDUCE_EN: when x_i < m_i at the accepted
// start, the first REDUCE cycle loads r = x directly and SCALE follows,
// giving a latency of k+2 edges instead of DATA_W+k+1.
//
// Ports:
//   CLK_pci_sys_clk_p  in   clock, rising edge
//   rst_i              in   synchronous active-high reset
//   start_i            in   start request (sampled in IDLE only)
//   x_i     [DATA_W]   in   operand, any value
//   m_i     [DATA_W]   in   modulus, odd and >= 3 for a meaningful result
//   m_bl_i  [LEN_W]    in   k, modulus bit length, clamped to DATA_W
//   busy_o             out  conversion in progress (REDUCE or SCALE)
//   result_o[DATA_W]   out  x * 2^k mod m
//   valid_o            out  one-cycle pulse when result_o is updated
//   err_o              out  set with valid_o when m_i < 2, cleared on start
//   dbg_state_o [2]    out  current FSM state (0 IDLE,1 REDUCE,2 SCALE,3 DONE)
// -----------------------------------------------------------------------------

package params_pkg;
   localparam int DATA_LENGTH = 32;
endpackage

module montgomery_to_form_bs
   import params_pkg::*;
#(
   parameter int DATA_W = DATA_LENGTH,
   parameter int LEN_W  = DATA_LENGTH
) (
   input  logic              CLK_pci_sys_clk_p,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] x_i,
   input  logic [DATA_W-1:0] m_i,
   input  logic [LEN_W-1:0]  m_bl_i,
   output logic              busy_o,
   output logic [DATA_W-1:0] result_o,
   output logic              valid_o,
   output logic              err_o,
   output logic [1:0]        dbg_state_o
);

   // cnt must hold both DATA_W-1 (REDUCE) and k up to DATA_W (SCALE)
   localparam int CNT_W = $clog2(DATA_W + 1);
   // compare width for clamping m_bl_i, wide enough for either operand
   localparam int CMP_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REDUCE = 2'd1,
      S_SCALE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W:0]   r_q, r_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] m_q, m_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              err_q, err_d;
`ifdef MONT_FAST_REDUCE_EN
   logic              fast_q, fast_d;
`endif

   logic              m_bad;
   logic [CMP_W-1:0]  m_bl_ext;
   logic [CNT_W-1:0]  k_sel;
   logic              in_bit;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   stepped;

   assign m_bad    = (m_i < DATA_W'(2));
   assign m_bl_ext = CMP_W'(m_bl_i);
   assign k_sel    = (m_bl_ext >= CMP_W'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(m_bl_ext);

   // Shared doubling step for REDUCE and SCALE. Because r < m before each
   // doubling, 2r+1 < 2m and one conditional subtract restores r < m.
   // The extra top bit of r absorbs the carry of the doubling.
   assign in_bit  = (state_q == S_REDUCE) ? x_q[DATA_W-1] : 1'b0;
   assign shifted = (r_q << 1) | {{DATA_W{1'b0}}, in_bit};
   assign stepped = (shifted >= {1'b0, m_q}) ? (shifted - {1'b0, m_q}) : shifted;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge CLK_pci_sys_clk_p) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = m_bad ? S_DONE : S_REDUCE;
            end
         end
         S_REDUCE: begin
`ifdef MONT_FAST_REDUCE_EN
            if (fast_q || (cnt_q == '0)) begin
`else
            if (cnt_q == '0) begin
`endif
               state_d = (k_q == '0) ? S_DONE : S_SCALE;
            end
         end
         S_SCALE: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      r_d      = r_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      x_d      = x_q;
      m_d      = m_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef MONT_FAST_REDUCE_EN
      fast_d   = fast_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               x_d   = x_i;
               m_d   = m_i;
               k_d   = k_sel;
               r_d   = '0;
               cnt_d = CNT_W'(DATA_W - 1);
               err_d = m_bad;
`ifdef MONT_FAST_REDUCE_EN
               fast_d = (x_i < m_i);
`endif
            end
         end
         S_REDUCE: begin
`ifdef MONT_FAST_REDUCE_EN
            if (fast_q) begin
               // x already below m: it is its own residue
               r_d   = {1'b0, x_q};
               cnt_d = k_q;
            end else begin
`else
            begin
`endif
               r_d = stepped;
               x_d = x_q << 1;
               if (cnt_q == '0) begin
                  cnt_d = k_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         S_SCALE: begin
            r_d   = stepped;
            cnt_d = cnt_q - CNT_W'(1);
         end
         default: ;
      endcase

      // result_o changes exactly on entry to DONE so that it lines up with
      // valid_o; on the error path r_d is zero, giving a zero result
      if (state_d == S_DONE) begin
         result_d = r_d[DATA_W-1:0];
      end
   end

   always_ff @(posedge CLK_pci_sys_clk_p) begin
      if (rst_i) begin
         r_q      <= '0;
         cnt_q    <= '0;
         k_q      <= '0;
         x_q      <= '0;
         m_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef MONT_FAST_REDUCE_EN
         fast_q   <= 1'b0;
`endif
      end else begin
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         x_q      <= x_d;
         m_q      <= m_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef MONT_FAST_REDUCE_EN
         fast_q   <= fast_d;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy_o      = (state_q == S_REDUCE) || (state_q == S_SCALE);
      valid_o     = (state_q == S_DONE);
      err_o       = err_q;
      result_o    = result_q;
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_montgomery_to_form_bs.sv
// -----------------------------------------------------------------------------
// tb_montgomery_to_form_bs
//
// Directed bench for montgomery_to_form_bs (DATA_W = LEN_W = 32).
// Expected results are hand-computed constants; expected latencies follow
// DATA_W + min(k,DATA_W) + 1 edges counted from the edge that samples start_i
// (k+2 with the fast-reduce build when x < m).
// -----------------------------------------------------------------------------
module tb_montgomery_to_form_bs;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 32;
   localparam logic [31:0] Q = 32'd8380417;

   // ------------------------------------------------------------- clock/reset
   logic              clk = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic [DATA_W-1:0] x_i;
   logic [DATA_W-1:0] m_i;
   logic [LEN_W-1:0]  m_bl_i;
   logic              busy_o;
   logic [DATA_W-1:0] result_o;
   logic              valid_o;
   logic              err_o;
   logic [1:0]        dbg_state_o;

   always #5 clk = ~clk;

   montgomery_to_form_bs #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) dut (
      .CLK_pci_sys_clk_p (clk),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .x_i               (x_i),
      .m_i               (m_i),
      .m_bl_i            (m_bl_i),
      .busy_o            (busy_o),
      .result_o          (result_o),
      .valid_o           (valid_o),
      .err_o             (err_o),
      .dbg_state_o       (dbg_state_o)
   );

   // ------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_pass   = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------- drivers
   // One accepted conversion: checks latency, result, err_o, pulse width and
   // hold of result_o. Inputs are scrambled right after the sampling edge.
   task automatic convert(input string tag, input logic [31:0] xv, input logic [31:0] mv,
                          input logic [31:0] blv, input logic [31:0] exp_res);
      int  k;
      int  lat;
      int  n;
      bit  seen;
      logic [DATA_W-1:0] exp_v;
      k   = (blv > DATA_W) ? DATA_W : int'(blv);
      lat = DATA_W + k + 1;
`ifdef MONT_FAST_REDUCE_EN
      if (xv < mv) lat = k + 2;
`endif
      exp_q.push_back(exp_res);
      @(negedge clk);
      x_i = xv; m_i = mv; m_bl_i = blv; start_i = 1'b1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            start_i = 1'b0;
            x_i     = $urandom;
            m_i     = $urandom;
            m_bl_i  = $urandom_range(0, 63);
         end
         if (valid_o) seen = 1'b1;
      end
      exp_v = exp_q.pop_front();
      check({tag, "_valid_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_latency"}, n, lat);
         check({tag, "_result"}, result_o, exp_v);
         check({tag, "_err"}, err_o, 0);
         @(posedge clk); #1;
         check({tag, "_pulse"}, valid_o, 0);
         check({tag, "_hold"}, result_o, exp_v);
      end
   endtask

   // Conversion with an invalid modulus: immediate DONE with err_o.
   task automatic convert_err(input string tag, input logic [31:0] mv);
      int n;
      bit seen;
      @(negedge clk);
      x_i = $urandom; m_i = mv; m_bl_i = 23; start_i = 1'b1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) start_i = 1'b0;
         if (valid_o) seen = 1'b1;
      end
      check({tag, "_valid_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_latency_le2"}, (n <= 2), 1);
         check({tag, "_err"}, err_o, 1);
         check({tag, "_result"}, result_o, 0);
         check({tag, "_busy"}, busy_o, 0);
         @(posedge clk); #1;
         check({tag, "_pulse"}, valid_o, 0);
         check({tag, "_err_held"}, err_o, 1);
      end
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int nv;
      logic [DATA_W-1:0] res_seen;

      rst_i = 1'b1; start_i = 1'b0; x_i = '0; m_i = '0; m_bl_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   busy_o,      0);
      check("rst_valid",  valid_o,     0);
      check("rst_err",    err_o,       0);
      check("rst_result", result_o,    0);
      check("rst_state",  dbg_state_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      // 2^23 mod 8380417 = 8191
      convert("q_x1",        32'd1,          Q, 32'd23, 32'd8191);
      convert("q_x5",        32'd5,          Q, 32'd23, 32'd40955);
      convert("q_xq",        Q,              Q, 32'd23, 32'd0);
      convert("q_xq1",       Q + 32'd1,      Q, 32'd23, 32'd8191);
      convert("q_x0",        32'd0,          Q, 32'd23, 32'd0);
      // k = 0: plain x mod m, 0xFFFFFFFF = 512*8380417 + 4193791
      convert("q_k0_max",    32'hFFFF_FFFF,  Q, 32'd0,  32'd4193791);
      // m_bl_i = 40 clamps to 32: 2^32 mod q = 4193792
      convert("q_k_clamp",   32'd1,          Q, 32'd40, 32'd4193792);
      // m = 2^32-1: 2^32 = 1 mod m, so result = x mod m
      convert("mmax_xm1",    32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'd32, 32'hFFFF_FFFE);
      convert("mmax_xm",     32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd32, 32'd0);
      // small moduli: 7*4 mod 3 = 1, even m: 3*16 mod 10 = 8 with no error
      convert("m3",          32'd7,          32'd3,  32'd2, 32'd1);
      convert("m10_even",    32'd3,          32'd10, 32'd4, 32'd8);

      // invalid moduli, then a valid start clears err_o
      convert_err("m1", 32'd1);
      convert_err("m0", 32'd0);
      convert("after_err",   32'd5,          Q, 32'd23, 32'd40955);

      // reset asserted at edge 20 of a conversion
      @(negedge clk);
      x_i = 32'd1; m_i = Q; m_bl_i = 32'd23; start_i = 1'b1;
      for (int n = 1; n <= 19; n++) begin
         @(posedge clk); #1;
         if (n == 1) start_i = 1'b0;
      end
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      check("midrst_busy",   busy_o,      0);
      check("midrst_valid",  valid_o,     0);
      check("midrst_state",  dbg_state_o, 0);
      check("midrst_result", result_o,    0);
      nv = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (valid_o) nv++;
      end
      check("midrst_no_valid", nv, 0);
      convert("after_rst",   32'd5,          Q, 32'd23, 32'd40955);

      // start pulsed while busy is ignored
      @(negedge clk);
      x_i = 32'd1; m_i = Q; m_bl_i = 32'd23; start_i = 1'b1;
      nv = 0;
      res_seen = '0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (n == 1) start_i = 1'b0;
         if (n == 10) begin
            start_i = 1'b1;
            x_i     = 32'd5;
         end
         if (n == 11) start_i = 1'b0;
         if (valid_o) begin
            nv++;
            res_seen = result_o;
         end
      end
      check("busy_ign_count",  nv,       1);
      check("busy_ign_result", res_seen, 32'd8191);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
